// File: rtl/fir_pkg.sv
// Shared widths, sample/accumulator types and saturation limits
// for the FIR output buffer.
package fir_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int ACC_WIDTH  = 40;
    localparam int SHIFT      = 15;
    localparam int DEPTH      = 4;

    typedef logic signed [DATA_WIDTH-1:0] sample_t;
    typedef logic signed [ACC_WIDTH-1:0]  acc_t;

    localparam sample_t SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam sample_t SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

endpackage

// File: rtl/fir_out_buffer_if.sv
// Upstream accumulator handshake plus downstream sample handshake
// of the FIR output buffer; master = producer/consumer side.
interface fir_out_buffer_if
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH  = fir_pkg::ACC_WIDTH,
    parameter int DEPTH      = fir_pkg::DEPTH
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic                         in_valid;
    logic signed [ACC_WIDTH-1:0]  in_acc;
    logic                         in_ready;
    logic                         out_valid;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_ready;
    logic [CW-1:0]                count;

    modport master (
        output in_valid, in_acc, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_acc, out_ready,
        output in_ready, out_valid, out_data, count
    );

endinterface

// File: rtl/fir_round_sat.sv
// Combinational round-half-up, arithmetic shift and saturation of a
// wide signed accumulator down to the output sample width.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH  = fir_pkg::ACC_WIDTH,
    parameter int SHIFT      = fir_pkg::SHIFT
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic signed [DATA_WIDTH-1:0] sample,
    output logic                         saturated
);

    // One guard bit so adding the rounding constant cannot overflow.
    localparam int TW = ACC_WIDTH + 1;
    localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [TW-1:0] RND =
        (SHIFT > 0) ? (TW'(1) << RS) : '0;

    logic signed [TW-1:0] w_t;
    logic signed [TW-1:0] w_r;
    logic signed [TW-1:0] w_max;
    logic signed [TW-1:0] w_min;

    assign w_max = {{(TW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    assign w_min = {{(TW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        w_t       = {acc[ACC_WIDTH-1], acc} + RND;
        w_r       = w_t >>> SHIFT;
        sample    = w_r[DATA_WIDTH-1:0];
        saturated = 1'b0;
        if (w_r > w_max) begin
            sample    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
            saturated = 1'b1;
        end else if (w_r < w_min) begin
            sample    = {1'b1, {(DATA_WIDTH-1){1'b0}}};
            saturated = 1'b1;
        end
    end

endmodule

// File: rtl/fir_out_buffer.sv
// FIR output buffer: round/saturate accumulator samples into a small FIFO.
// Optional sticky saturation flag with FIR_OUT_SAT_FLAG_EN.
module fir_out_buffer
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH = fir_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH  = fir_pkg::ACC_WIDTH,
    parameter int SHIFT      = fir_pkg::SHIFT,
    parameter int DEPTH      = fir_pkg::DEPTH
) (
    input  logic            clk,
    input  logic            reset,
    fir_out_buffer_if.slave bus
`ifdef FIR_OUT_SAT_FLAG_EN
    ,
    input  logic            sat_clr,
    output logic            sat_flag
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]                r_wr_ptr;
    logic [PW-1:0]                r_rd_ptr;
    logic [CW-1:0]                r_count;

    logic                         w_full;
    logic                         w_empty;
    logic                         w_push;
    logic                         w_pop;
    logic signed [DATA_WIDTH-1:0] w_sample;
    logic                         w_sat;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid && !w_full;
    assign w_pop   = bus.out_ready && !w_empty;

    fir_round_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SHIFT      (SHIFT)
    ) u_round_sat (
        .acc       (bus.in_acc),
        .sample    (w_sample),
        .saturated (w_sat)
    );

    // Storage is never reset; empty masking keeps stale data hidden.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_sample;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign bus.count     = r_count;

`ifdef FIR_OUT_SAT_FLAG_EN
    logic r_sat_flag;

    // A saturating push outranks a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sat_flag <= 1'b0;
        end else if (w_push && w_sat) begin
            r_sat_flag <= 1'b1;
        end else if (sat_clr) begin
            r_sat_flag <= 1'b0;
        end
    end

    assign sat_flag = r_sat_flag;
`else
    logic w_unused_sat;
    assign w_unused_sat = w_sat;
`endif

endmodule

// File: tb/tb_fir_out_buffer.sv
// Scenario bench for fir_out_buffer with an expected-sample queue.
// Sat-flag scenarios compile in with FIR_OUT_SAT_FLAG_EN.
module tb_fir_out_buffer;
    import fir_pkg::*;

    logic clk = 1'b0;
    logic reset;
`ifdef FIR_OUT_SAT_FLAG_EN
    logic sat_clr;
    logic sat_flag;
`endif

    int checks = 0;
    int errors = 0;
    int q[$];

    fir_out_buffer_if bus ();

    fir_out_buffer dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus.slave)
`ifdef FIR_OUT_SAT_FLAG_EN
        ,
        .sat_clr  (sat_clr),
        .sat_flag (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    function automatic int model(input acc_t a);
        longint t;
        t = longint'(a) + 64'sd16384;
        t = t >>> 15;
        if (t > longint'(SAT_MAX)) return int'(SAT_MAX);
        if (t < longint'(SAT_MIN)) return int'(SAT_MIN);
        return int'(t);
    endfunction

    // One cycle from a falling edge to the next; the model decides
    // acceptance from its own occupancy.
    task automatic drive(input bit v, input acc_t a, input bit rdy,
                         output bit popped, output int exp_d,
                         output int act_d);
        int occ;
        bus.in_valid  = v;
        bus.in_acc    = a;
        bus.out_ready = rdy;
        #1;
        occ    = q.size();
        popped = rdy && (occ > 0);
        act_d  = int'(bus.out_data);
        exp_d  = 0;
        if (popped) exp_d = q.pop_front();
        if (v && occ < DEPTH) q.push_back(model(a));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        bus.in_valid  = 1'b0;
        bus.in_acc    = '0;
        bus.out_ready = 1'b0;
`ifdef FIR_OUT_SAT_FLAG_EN
        sat_clr = 1'b0;
`endif
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks += 4;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid);
        end
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready);
        end
        if (bus.count !== 3'd0) begin
            errors++; $display("FAIL rst_count got %0d want 0", bus.count);
        end
        if (bus.out_data !== 16'sd0) begin
            errors++; $display("FAIL rst_out_data got %0d want 0", bus.out_data);
        end
`ifdef FIR_OUT_SAT_FLAG_EN
        checks++;
        if (sat_flag !== 1'b0) begin
            errors++; $display("FAIL rst_sat_flag got %b want 0", sat_flag);
        end
`endif
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit p; int e, a;
        drive(1, 40'sh4000, 0, p, e, a);
        checks += 2;
        if (bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL latency_valid got %b want 1", bus.out_valid);
        end
        if (bus.count !== 3'd1) begin
            errors++; $display("FAIL basic_count1 got %0d want 1", bus.count);
        end
        drive(1, 40'sh3FFF, 0, p, e, a);
        for (int i = 0; i < 2; i++) begin
            drive(0, '0, 1, p, e, a);
            checks++;
            if (!p || a !== e) begin
                errors++; $display("FAIL basic_data[%0d] got %0d want %0d", i, a, e);
            end
        end
        checks += 2;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL basic_empty got %b want 0", bus.out_valid);
        end
        if (bus.count !== 3'd0) begin
            errors++; $display("FAIL basic_count0 got %0d want 0", bus.count);
        end
    endtask

    task automatic test_rounding;
        acc_t v [3] = '{-40'sd16384, -40'sd16385, 40'sd49152};
        bit p; int e, a;
        for (int i = 0; i < 3; i++) begin
            drive(1, v[i], 1, p, e, a);
            if (p) begin
                checks++;
                if (a !== e) begin
                    errors++; $display("FAIL round_data got %0d want %0d", a, e);
                end
            end
        end
        for (int i = 0; i < 4 && q.size() > 0; i++) begin
            drive(0, '0, 1, p, e, a);
            checks++;
            if (a !== e) begin
                errors++; $display("FAIL round_drain got %0d want %0d", a, e);
            end
        end
    endtask

    task automatic test_saturation;
        acc_t big;
        bit p; int e, a;
        big = 40'sd1 <<< 38;
        drive(1, big, 0, p, e, a);
`ifdef FIR_OUT_SAT_FLAG_EN
        checks++;
        if (sat_flag !== 1'b1) begin
            errors++; $display("FAIL sat_flag_set got %b want 1", sat_flag);
        end
`endif
        drive(1, -big, 0, p, e, a);
        drive(1, 40'sd3 <<< 15, 0, p, e, a);
`ifdef FIR_OUT_SAT_FLAG_EN
        checks++;
        if (sat_flag !== 1'b1) begin
            errors++; $display("FAIL sat_flag_sticky got %b want 1", sat_flag);
        end
`endif
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 1, p, e, a);
            checks++;
            if (!p || a !== e) begin
                errors++; $display("FAIL sat_data[%0d] got %0d want %0d", i, a, e);
            end
        end
`ifdef FIR_OUT_SAT_FLAG_EN
        sat_clr = 1'b1;
        drive(0, '0, 0, p, e, a);
        sat_clr = 1'b0;
        checks++;
        if (sat_flag !== 1'b0) begin
            errors++; $display("FAIL sat_flag_clr got %b want 0", sat_flag);
        end
        sat_clr = 1'b1;
        drive(1, big, 0, p, e, a);
        sat_clr = 1'b0;
        checks++;
        if (sat_flag !== 1'b1) begin
            errors++; $display("FAIL sat_set_wins got %b want 1", sat_flag);
        end
        drive(0, '0, 1, p, e, a);
        checks++;
        if (!p || a !== e) begin
            errors++; $display("FAIL sat_data_last got %0d want %0d", a, e);
        end
`endif
    endtask

    task automatic test_full;
        bit p; int e, a;
        for (int k = 1; k <= 4; k++)
            drive(1, acc_t'(k) <<< 15, 0, p, e, a);
        checks += 2;
        if (bus.count !== 3'd4) begin
            errors++; $display("FAIL full_count got %0d want 4", bus.count);
        end
        if (bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL full_in_ready got %b want 0", bus.in_ready);
        end
        drive(1, 40'sd5 <<< 15, 0, p, e, a);
        checks++;
        if (bus.count !== 3'd4) begin
            errors++; $display("FAIL full_ignore got %0d want 4", bus.count);
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, 1, p, e, a);
            checks++;
            if (!p || a !== e) begin
                errors++; $display("FAIL full_data[%0d] got %0d want %0d", i, a, e);
            end
            if (i == 0) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin
                    errors++; $display("FAIL full_release got %b want 1", bus.in_ready);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        bit p; int e, a;
        drive(1, 40'sd100 <<< 15, 0, p, e, a);
        drive(1, 40'sd101 <<< 15, 0, p, e, a);
        for (int i = 0; i < 20; i++) begin
            drive(1, acc_t'(200 + i) <<< 15, 1, p, e, a);
            checks += 2;
            if (!p || a !== e) begin
                errors++; $display("FAIL b2b_data[%0d] got %0d want %0d", i, a, e);
            end
            if (bus.count !== 3'd2) begin
                errors++; $display("FAIL b2b_count[%0d] got %0d want 2", i, bus.count);
            end
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, '0, 1, p, e, a);
            checks++;
            if (!p || a !== e) begin
                errors++; $display("FAIL b2b_drain[%0d] got %0d want %0d", i, a, e);
            end
        end
    endtask

    task automatic test_mid_reset;
        bit p; int e, a;
        for (int k = 1; k <= 3; k++)
            drive(1, acc_t'(50 + k) <<< 15, 0, p, e, a);
        checks++;
        if (bus.count !== 3'd3) begin
            errors++; $display("FAIL mrst_pre_count got %0d want 3", bus.count);
        end
        bus.in_valid = 1'b0;
        #1 reset = 1'b0;
        #1;
        q.delete();
        checks += 3;
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL mrst_out_valid got %b want 0", bus.out_valid);
        end
        if (bus.count !== 3'd0) begin
            errors++; $display("FAIL mrst_count got %0d want 0", bus.count);
        end
        if (bus.in_ready !== 1'b1) begin
            errors++; $display("FAIL mrst_in_ready got %b want 1", bus.in_ready);
        end
        #1 reset = 1'b1;
        @(negedge clk);
        drive(1, 40'sd7 <<< 15, 0, p, e, a);
        checks++;
        if (bus.count !== 3'd1) begin
            errors++; $display("FAIL mrst_post_count got %0d want 1", bus.count);
        end
        drive(0, '0, 1, p, e, a);
        checks += 2;
        if (!p || a !== e) begin
            errors++; $display("FAIL mrst_data got %0d want %0d", a, e);
        end
        if (bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL mrst_alone got %b want 0", bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_full();
        test_back_to_back();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
